decode_control_stage: RTL

Registered, parametrised successor to the combinational control decoder in the pipelined RISC-V core. It sits at the ID/EX boundary and decodes the full 32-bit instruction into the standard control bundle, then registers that bundle into the ID/EX stage. It adds the behaviour the pipeline now needs: hold and flush, multi-cycle occupancy for M-extension mul/div, and a sticky halt on ECALL/EBREAK.

---
 rtl/decode_control_stage.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/decode_control_stage.sv
// ID/EX control decoder: decodes a 32-bit RV32 instruction into a registered control bundle,
// with hold/flush, multi-cycle mul/div occupancy and a sticky halt on ECALL/EBREAK.
module decode_control_stage #(
    parameter int unsigned ENABLE_M      = 1,
    parameter int unsigned MULDIV_CYCLES = 4,
    parameter int unsigned HALT_ON_SYS   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid,
    input  logic [31:0] inst,
    input  logic        stall_in,
    input  logic        flush,
    output logic        ctrl_valid,
    output logic        branch,
    output logic        memread,
    output logic        memtoreg,
    output logic        memwrite,
    output logic        alusrc,
    output logic        regwrite,
    output logic        jalr_jump,
    output logic        jal_jump,
    output logic [1:0]  regwrite_sel,
    output logic [2:0]  aluop,
    output logic        muldiv,
    output logic        stall_out,
    output logic        halted
);
    localparam int unsigned      CNT_W    = $clog2(MULDIV_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    localparam logic [4:0] OPCODE_R      = 5'b01100;
    localparam logic [4:0] OPCODE_I      = 5'b00100;
    localparam logic [4:0] OPCODE_LOAD   = 5'b00000;
    localparam logic [4:0] OPCODE_STORE  = 5'b01000;
    localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
    localparam logic [4:0] OPCODE_JALR   = 5'b11001;
    localparam logic [4:0] OPCODE_JAL    = 5'b11011;
    localparam logic [4:0] OPCODE_LUI    = 5'b01101;
    localparam logic [4:0] OPCODE_AUIPC  = 5'b00101;

    localparam logic [2:0] ALUOP_Load_Store = 3'b000;
    localparam logic [2:0] ALUOP_Branch     = 3'b001;
    localparam logic [2:0] ALUOP_R_I        = 3'b010;
    localparam logic [2:0] ALUOP_JALR       = 3'b011;
    localparam logic [2:0] ALUOP_OTHER      = 3'b111;

    typedef struct packed {
        logic       valid;
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic       jalr_jump;
        logic       jal_jump;
        logic [1:0] wb_sel;
        logic [2:0] aluop;
        logic       muldiv;
    } ctrl_t;

    localparam ctrl_t C_BUBBLE = '{
        valid: 1'b0, branch: 1'b0, memread: 1'b0, memtoreg: 1'b0, memwrite: 1'b0,
        alusrc: 1'b0, regwrite: 1'b0, jalr_jump: 1'b0, jal_jump: 1'b0,
        wb_sel: 2'b00, aluop: ALUOP_OTHER, muldiv: 1'b0
    };

    typedef enum logic [1:0] {RUN, MULTI, HALT} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    ctrl_t            r_ctrl;

    logic [4:0] w_opcode;
    logic       w_is_muldiv;
    logic       w_is_sys;
    ctrl_t      w_dec;

    assign w_opcode    = inst[6:2];
    assign w_is_muldiv = (ENABLE_M != 0) && (w_opcode == OPCODE_R) && (inst[31:25] == 7'b0000001);
    assign w_is_sys    = (inst == 32'h00000073) || (inst == 32'h00100073);

    always_comb begin
        w_dec       = C_BUBBLE;
        w_dec.valid = 1'b1;
        case (w_opcode)
            OPCODE_R: begin
                w_dec.regwrite = 1'b1;
                w_dec.aluop    = ALUOP_R_I;
                w_dec.muldiv   = w_is_muldiv;
            end
            OPCODE_I: begin
                w_dec.alusrc   = 1'b1;
                w_dec.regwrite = 1'b1;
                w_dec.aluop    = ALUOP_R_I;
            end
            OPCODE_LOAD: begin
                w_dec.memread  = 1'b1;
                w_dec.memtoreg = 1'b1;
                w_dec.alusrc   = 1'b1;
                w_dec.regwrite = 1'b1;
                w_dec.aluop    = ALUOP_Load_Store;
            end
            OPCODE_STORE: begin
                w_dec.memwrite = 1'b1;
                w_dec.alusrc   = 1'b1;
                w_dec.aluop    = ALUOP_Load_Store;
            end
            OPCODE_BRANCH: begin
                w_dec.branch = 1'b1;
                w_dec.aluop  = ALUOP_Branch;
            end
            OPCODE_JALR: begin
                w_dec.alusrc    = 1'b1;
                w_dec.regwrite  = 1'b1;
                w_dec.wb_sel    = 2'b01;
                w_dec.jalr_jump = 1'b1;
                w_dec.aluop     = ALUOP_JALR;
            end
            OPCODE_JAL: begin
                w_dec.regwrite = 1'b1;
                w_dec.wb_sel   = 2'b01;
                w_dec.jal_jump = 1'b1;
            end
            OPCODE_LUI: begin
                w_dec.regwrite = 1'b1;
                w_dec.wb_sel   = 2'b10;
            end
            OPCODE_AUIPC: begin
                w_dec.regwrite = 1'b1;
                w_dec.wb_sel   = 2'b11;
            end
            default: w_dec = C_BUBBLE;
        endcase
    end

    // MULTI keeps the mul/div bundle in place; returning to RUN leaves it visible one more cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_ctrl  <= C_BUBBLE;
        end else begin
            case (r_state)
                RUN: begin
                    if (flush) begin
                        r_ctrl <= C_BUBBLE;
                    end else if (stall_in) begin
                        r_ctrl <= r_ctrl;
                    end else if (inst_valid && w_is_sys && (HALT_ON_SYS != 0)) begin
                        r_ctrl  <= C_BUBBLE;
                        r_state <= HALT;
                    end else if (inst_valid) begin
                        r_ctrl <= w_dec;
                        if (w_is_muldiv && (MULDIV_CYCLES > 1)) begin
                            r_cnt   <= CNT_LOAD;
                            r_state <= MULTI;
                        end
                    end else begin
                        r_ctrl <= C_BUBBLE;
                    end
                end
                MULTI: begin
                    if (flush) begin
                        r_ctrl  <= C_BUBBLE;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end else if (!stall_in) begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= RUN;
                        end
                    end
                end
                HALT: begin
                    r_ctrl <= C_BUBBLE;
                end
                default: begin
                    r_ctrl  <= C_BUBBLE;
                    r_cnt   <= '0;
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign ctrl_valid   = r_ctrl.valid;
    assign branch       = r_ctrl.branch;
    assign memread      = r_ctrl.memread;
    assign memtoreg     = r_ctrl.memtoreg;
    assign memwrite     = r_ctrl.memwrite;
    assign alusrc       = r_ctrl.alusrc;
    assign regwrite     = r_ctrl.regwrite;
    assign jalr_jump    = r_ctrl.jalr_jump;
    assign jal_jump     = r_ctrl.jal_jump;
    assign regwrite_sel = r_ctrl.wb_sel;
    assign aluop        = r_ctrl.aluop;
    assign muldiv       = r_ctrl.muldiv;
    assign stall_out    = (r_state == MULTI) || (r_state == HALT);
    assign halted       = (r_state == HALT);

endmodule
